mem_write_sniffer: RTL and testbench
====================================

// Module: mem_write_sniffer
// PURPOSE
//  Passive monitor on the CPU data-memory write bus that turns each completed store into exactly
//  one timestamped event. Repeated cycles caused by D-cache stalls (wen held high) are suppressed.
//  Events are buffered in a FIFO and handed to the downstream result checker over valid/ready.
//  Sits between the CPU/D-cache memory interface and the testbench checker; never drives the bus.
// PARAMETERS
//  WIN_BASE   30'h0   first word address captured (inclusive)
//  WIN_SIZE   64      number of word addresses captured starting at WIN_BASE
//  FIFO_DEPTH 8       event FIFO entries; power of two, >=2
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  bus_addr   in   30  word address on memory bus
//  bus_wdata  in   32  write data on memory bus
//  bus_wen    in   1   write enable from D-cache
//  bus_ready  in   1   memory acknowledge; write completes when bus_wen && bus_ready
//  evt_valid  out  1   FIFO head holds an event
//  evt_addr   out  30  event word address
//  evt_data   out  32  event write data
//  evt_time   out  16  cycle stamp of completion
//  evt_ready  in   1   checker consumes head when evt_valid && evt_ready
//  overflow   out  1   sticky: an in-window event was dropped because FIFO was full
//  drop_cnt   out  8   dropped-event count, saturates at 8'hFF
//  evt_total  out  16  accepted-event count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, evt_valid=0, evt_addr/data/time=0, overflow=0, drop_cnt=0,
//   evt_total=0, cycle counter=0. Reset mid-operation discards all queued events.
//  Cycle counter: +1 every clk after reset, saturates at 16'hFFFF; its current value is
//   stamped into the event in the completion cycle.
//  FSM (state held in flops, next-state combinational):
//   IDLE : bus_wen&&bus_ready -> capture, go HOLD; bus_wen&&!bus_ready -> WAIT; else IDLE.
//   WAIT : bus_ready -> capture, go HOLD (if bus_wen still 1) or IDLE (if bus_wen 0, no capture);
//          !bus_wen -> IDLE (aborted write, no event).
//   HOLD : bus_wen=1 -> stay HOLD, no further capture (stall duplicate); bus_wen=0 -> IDLE.
//  Capture = completion with WIN_BASE <= bus_addr < WIN_BASE+WIN_SIZE (compare in 31 bits,
//   no wrap past 30'h3FFFFFFF). Out-of-window completions advance FSM but create no event.
//  Push latency: event visible on evt_* the cycle after completion (1-cycle latency) if FIFO was empty.
//  FIFO: first-word-fall-through; evt_* show head, hold stable while evt_valid && !evt_ready.
//   Pop when evt_valid&&evt_ready. Full && capture && pop same cycle -> both occur, no drop.
//   Full && capture && no pop -> drop: overflow<=1, drop_cnt+1 (saturating), evt_total unchanged.
//   Empty: evt_valid=0, evt_ready ignored, evt_* hold last value.
//  Accepted push -> evt_total+1 (saturating). Pointers wrap modulo FIFO_DEPTH; count width
//   log2(FIFO_DEPTH)+1 to distinguish full from empty.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE=2'b00, WAIT=2'b01, HOLD=2'b10),
//   event width constant EVT_W=78 and field offsets {time,addr,data}.
//  One sub-module: wr_evt_fifo (sync FWFT FIFO, EVT_W wide, FIFO_DEPTH deep, full/empty out).
//  Top holds FSM, window compare, cycle counter, drop/total counters.
// TESTING
//  Single write addr=0 data=5, wen&ready 1 cycle, evt_ready=1 -> one event {0,5}, evt_total=1.
//  Write addr=1 data=4, wen held 4 cycles, ready on cycle 3 -> exactly one event, stamp = cycle 3.
//  wen high 2 cycles, ready never, wen drops -> no event, FSM back to IDLE, evt_total unchanged.
//  Write addr=WIN_BASE+WIN_SIZE -> no event; addr=WIN_BASE+WIN_SIZE-1 -> event.
//  evt_ready=0, 10 in-window writes, depth 8 -> 8 events in order, overflow=1, drop_cnt=2.
//  FIFO full, capture with evt_ready=1 same cycle -> no drop, count stays 8; rst pulse -> all outputs 0.

Source files
------------

// File: rtl/mem_write_sniffer_pkg.sv
// Shared types and constants for the memory write sniffer.
package mem_write_sniffer_pkg;

    // Sniffer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } sniff_state_t;

    // Event word layout: {time, addr, data}
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned TIME_W   = 16;
    localparam int unsigned EVT_W    = 78;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned ADDR_LSB = DATA_LSB + DATA_W;
    localparam int unsigned TIME_LSB = ADDR_LSB + ADDR_W;

    // Build an event word from its fields
    function automatic logic [EVT_W-1:0] pack_evt(input logic [TIME_W-1:0] t,
                                                   input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] d);
        return {t, a, d};
    endfunction

endpackage

// File: rtl/mem_write_sniffer_fifo.sv
// Synchronous first-word-fall-through event FIFO. When empty the read
// port keeps presenting the most recently popped entry.
module wr_evt_fifo
    import mem_write_sniffer_pkg::*;
#(
    parameter int unsigned WIDTH = EVT_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and last-popped hold register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_write_sniffer.sv
// Passive store monitor: one timestamped event per completed in-window
// write, stall duplicates suppressed, events queued for the checker.
module mem_write_sniffer
    import mem_write_sniffer_pkg::*;
#(
    parameter logic [29:0] WIN_BASE   = 30'h0,
    parameter int unsigned WIN_SIZE   = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_wen,
    input  logic        bus_ready,
    output logic        evt_valid,
    output logic [29:0] evt_addr,
    output logic [31:0] evt_data,
    output logic [15:0] evt_time,
    input  logic        evt_ready,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic [15:0] evt_total
);

    // Window bounds in 31 bits so the end never wraps past the top address
    localparam logic [30:0] WIN_LO = {1'b0, WIN_BASE};
    localparam logic [30:0] WIN_HI = {1'b0, WIN_BASE} + 31'(WIN_SIZE);

    sniff_state_t      state;
    logic [15:0]       cyc_cnt;
    logic              completion;
    logic              in_window;
    logic              capture;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EVT_W-1:0]  evt_in;
    logic [EVT_W-1:0]  evt_out;

    // A store completes only once per transaction; HOLD covers stall repeats
    assign completion = bus_wen && bus_ready && (state == IDLE || state == WAIT);
    assign in_window  = ({1'b0, bus_addr} >= WIN_LO) && ({1'b0, bus_addr} < WIN_HI);
    assign capture    = completion && in_window;
    assign drop       = capture && fifo_full && !evt_ready;
    assign evt_in     = pack_evt(cyc_cnt, bus_addr, bus_wdata);

    // Bus transaction tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_wen && bus_ready) state <= HOLD;
                    else if (bus_wen)         state <= WAIT;
                end
                WAIT: begin
                    if (bus_ready)     state <= bus_wen ? HOLD : IDLE;
                    else if (!bus_wen) state <= IDLE;
                end
                HOLD: begin
                    if (!bus_wen) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating free-running cycle stamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cyc_cnt <= '0;
        else if (cyc_cnt != '1)  cyc_cnt <= cyc_cnt + 16'd1;
    end

    // Drop and accept statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            evt_total <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
        end else if (capture) begin
            if (evt_total != '1) evt_total <= evt_total + 16'd1;
        end
    end

    wr_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata (evt_in),
        .pop   (evt_ready),
        .rdata (evt_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_data  = evt_out[DATA_LSB +: DATA_W];
    assign evt_addr  = evt_out[ADDR_LSB +: ADDR_W];
    assign evt_time  = evt_out[TIME_LSB +: TIME_W];

endmodule

// File: tb/tb_mem_write_sniffer.sv
// Directed self-checking bench for mem_write_sniffer (default parameters).
module tb_mem_write_sniffer;
    import mem_write_sniffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_wen = 1'b0;
    logic        bus_ready = 1'b0;
    logic        evt_valid;
    logic [29:0] evt_addr;
    logic [31:0] evt_data;
    logic [15:0] evt_time;
    logic        evt_ready = 1'b0;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [15:0] evt_total;

    int checks = 0;
    int errors = 0;

    // Reference cycle stamp: 0 in reset, +1 per clock after, saturating
    logic [15:0] tb_cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= '0;
        else if (tb_cyc != 16'hFFFF) tb_cyc <= tb_cyc + 16'd1;
    end

    always #5 clk = ~clk;

    mem_write_sniffer #(
        .WIN_BASE   (30'h0),
        .WIN_SIZE   (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wen   (bus_wen),
        .bus_ready (bus_ready),
        .evt_valid (evt_valid),
        .evt_addr  (evt_addr),
        .evt_data  (evt_data),
        .evt_time  (evt_time),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .evt_total (evt_total)
    );

    // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", evt_valid); end
        checks++; if (evt_addr !== 30'h0) begin errors++; $display("FAIL reset_addr got %0h exp 0", evt_addr); end
        checks++; if (evt_data !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", evt_data); end
        checks++; if (evt_time !== 16'h0) begin errors++; $display("FAIL reset_time got %0h exp 0", evt_time); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0h exp 0", overflow); end
        checks++; if (drop_cnt !== 8'h0) begin errors++; $display("FAIL reset_drop got %0h exp 0", drop_cnt); end
        checks++; if (evt_total !== 16'h0) begin errors++; $display("FAIL reset_total got %0h exp 0", evt_total); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        logic [15:0] t0;
        evt_ready = 1'b1;
        bus_addr = 30'd0; bus_wdata = 32'd5; bus_wen = 1'b1; bus_ready = 1'b1;
        t0 = tb_cyc;
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", evt_valid); end
        checks++; if (evt_addr !== 30'd0) begin errors++; $display("FAIL single_addr got %0h exp 0", evt_addr); end
        checks++; if (evt_data !== 32'd5) begin errors++; $display("FAIL single_data got %0h exp 5", evt_data); end
        checks++; if (evt_time !== t0) begin errors++; $display("FAIL single_time got %0h exp %0h", evt_time, t0); end
        checks++; if (evt_total !== 16'd1) begin errors++; $display("FAIL single_total got %0h exp 1", evt_total); end
        cyc();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0h exp 0", evt_valid); end
        checks++; if (evt_data !== 32'd5) begin errors++; $display("FAIL single_hold_data got %0h exp 5", evt_data); end
    endtask

    task automatic test_stall();
        logic [15:0] t3;
        evt_ready = 1'b0;
        bus_addr = 30'd1; bus_wdata = 32'd4; bus_wen = 1'b1; bus_ready = 1'b0;
        cyc();
        cyc();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL stall_early got %0h exp 0", evt_valid); end
        bus_ready = 1'b1;
        t3 = tb_cyc;
        cyc();
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %0h exp 1", evt_valid); end
        checks++; if (evt_time !== t3) begin errors++; $display("FAIL stall_time got %0h exp %0h", evt_time, t3); end
        checks++; if (evt_data !== 32'd4) begin errors++; $display("FAIL stall_data got %0h exp 4", evt_data); end
        // fourth cycle: wen still high (with ready) is a stall duplicate
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0;
        checks++; if (evt_total !== 16'd2) begin errors++; $display("FAIL stall_total got %0h exp 2", evt_total); end
        checks++; if (evt_addr !== 30'd1) begin errors++; $display("FAIL stall_addr got %0h exp 1", evt_addr); end
        evt_ready = 1'b1;
        cyc();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL stall_single_event got %0h exp 0", evt_valid); end
    endtask

    task automatic test_abort();
        evt_ready = 1'b1;
        bus_addr = 30'd2; bus_wdata = 32'd9; bus_wen = 1'b1; bus_ready = 1'b0;
        cyc();
        cyc();
        checks++; if (dut.state !== WAIT) begin errors++; $display("FAIL abort_wait got %0h exp %0h", dut.state, WAIT); end
        bus_wen = 1'b0;
        cyc();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL abort_idle got %0h exp %0h", dut.state, IDLE); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %0h exp 0", evt_valid); end
        checks++; if (evt_total !== 16'd2) begin errors++; $display("FAIL abort_total got %0h exp 2", evt_total); end
    endtask

    task automatic test_window();
        logic [15:0] t;
        evt_ready = 1'b1;
        bus_addr = 30'd64; bus_wdata = 32'h77; bus_wen = 1'b1; bus_ready = 1'b1;
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL window_above got %0h exp 0", evt_valid); end
        checks++; if (evt_total !== 16'd2) begin errors++; $display("FAIL window_above_total got %0h exp 2", evt_total); end
        cyc();
        bus_addr = 30'h3FFFFFFF; bus_wdata = 32'h66; bus_wen = 1'b1; bus_ready = 1'b1;
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL window_top got %0h exp 0", evt_valid); end
        cyc();
        bus_addr = 30'd63; bus_wdata = 32'h88; bus_wen = 1'b1; bus_ready = 1'b1;
        t = tb_cyc;
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL window_last_valid got %0h exp 1", evt_valid); end
        checks++; if (evt_addr !== 30'd63) begin errors++; $display("FAIL window_last_addr got %0h exp 3f", evt_addr); end
        checks++; if (evt_data !== 32'h88) begin errors++; $display("FAIL window_last_data got %0h exp 88", evt_data); end
        checks++; if (evt_time !== t) begin errors++; $display("FAIL window_last_time got %0h exp %0h", evt_time, t); end
        checks++; if (evt_total !== 16'd3) begin errors++; $display("FAIL window_last_total got %0h exp 3", evt_total); end
        cyc();
    endtask

    logic [15:0] ovf_t [10];
    logic [15:0] t_new;

    task automatic test_overflow();
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_addr = 30'(8 + i); bus_wdata = 32'hA000 + 32'(i); bus_wen = 1'b1; bus_ready = 1'b1;
            ovf_t[i] = tb_cyc;
            cyc();
            bus_wen = 1'b0; bus_ready = 1'b0;
            cyc();
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0h exp 2", drop_cnt); end
        checks++; if (evt_total !== 16'd11) begin errors++; $display("FAIL ovf_total got %0h exp b", evt_total); end
        checks++; if (evt_addr !== 30'd8) begin errors++; $display("FAIL ovf_head_addr got %0h exp 8", evt_addr); end
        checks++; if (evt_data !== 32'hA000) begin errors++; $display("FAIL ovf_head_data got %0h exp a000", evt_data); end
        checks++; if (evt_time !== ovf_t[0]) begin errors++; $display("FAIL ovf_head_time got %0h exp %0h", evt_time, ovf_t[0]); end
    endtask

    task automatic test_full_pop_push();
        logic [29:0] ea;
        logic [31:0] ed;
        logic [15:0] et;
        evt_ready = 1'b1;
        bus_addr = 30'd20; bus_wdata = 32'hBEEF; bus_wen = 1'b1; bus_ready = 1'b1;
        t_new = tb_cyc;
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0; evt_ready = 1'b0;
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fullpop_drop got %0h exp 2", drop_cnt); end
        checks++; if (evt_total !== 16'd12) begin errors++; $display("FAIL fullpop_total got %0h exp c", evt_total); end
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin ea = 30'(9 + k); ed = 32'hA001 + 32'(k); et = ovf_t[k+1]; end
            else begin ea = 30'd20; ed = 32'hBEEF; et = t_new; end
            checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %0h exp 1", k, evt_valid); end
            checks++; if (evt_addr !== ea) begin errors++; $display("FAIL drain_addr[%0d] got %0h exp %0h", k, evt_addr, ea); end
            checks++; if (evt_data !== ed) begin errors++; $display("FAIL drain_data[%0d] got %0h exp %0h", k, evt_data, ed); end
            checks++; if (evt_time !== et) begin errors++; $display("FAIL drain_time[%0d] got %0h exp %0h", k, evt_time, et); end
            evt_ready = 1'b1;
            cyc();
            evt_ready = 1'b0;
        end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0h exp 0", evt_valid); end
        checks++; if (evt_data !== 32'hBEEF) begin errors++; $display("FAIL drain_hold got %0h exp beef", evt_data); end
    endtask

    task automatic test_drop_saturate();
        evt_ready = 1'b0;
        for (int i = 0; i < 268; i++) begin
            bus_addr = 30'd30; bus_wdata = 32'(i); bus_wen = 1'b1; bus_ready = 1'b1;
            cyc();
            bus_wen = 1'b0; bus_ready = 1'b0;
            cyc();
            if (i == 107) begin
                checks++; if (drop_cnt !== 8'd102) begin errors++; $display("FAIL drop_mid got %0d exp 102", drop_cnt); end
            end
        end
        checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat got %0h exp ff", drop_cnt); end
        checks++; if (evt_total !== 16'd20) begin errors++; $display("FAIL drop_total got %0h exp 14", evt_total); end
        checks++; if (evt_data !== 32'd0) begin errors++; $display("FAIL drop_head got %0h exp 0", evt_data); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] t;
        #2 rst = 1'b1;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid got %0h exp 0", evt_valid); end
        checks++; if (evt_addr !== 30'h0) begin errors++; $display("FAIL rst2_addr got %0h exp 0", evt_addr); end
        checks++; if (evt_data !== 32'h0) begin errors++; $display("FAIL rst2_data got %0h exp 0", evt_data); end
        checks++; if (evt_time !== 16'h0) begin errors++; $display("FAIL rst2_time got %0h exp 0", evt_time); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst2_overflow got %0h exp 0", overflow); end
        checks++; if (drop_cnt !== 8'h0) begin errors++; $display("FAIL rst2_drop got %0h exp 0", drop_cnt); end
        checks++; if (evt_total !== 16'h0) begin errors++; $display("FAIL rst2_total got %0h exp 0", evt_total); end
        cyc();
        rst = 1'b0;
        evt_ready = 1'b1;
        bus_addr = 30'd5; bus_wdata = 32'd6; bus_wen = 1'b1; bus_ready = 1'b1;
        t = tb_cyc;
        cyc();
        bus_wen = 1'b0; bus_ready = 1'b0;
        checks++; if (evt_time !== t) begin errors++; $display("FAIL rst2_restamp got %0h exp %0h", evt_time, t); end
        checks++; if (evt_total !== 16'd1) begin errors++; $display("FAIL rst2_total_after got %0h exp 1", evt_total); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall();
        test_abort();
        test_window();
        test_overflow();
        test_full_pop_push();
        test_drop_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
